// File: rtl/plate_pkg.sv
// rtl/plate_pkg.sv - shared plate constants and sequencer state encoding
package plate_pkg;
   localparam int CH_W       = 6;
   localparam int MAX_CHARS  = 7;
   localparam int BLANK_CODE = 40;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DISPLAY = 2'd2
   } state_e;
endpackage

// File: rtl/plate_char_sequencer_dwell_timer.sv
// rtl/plate_char_sequencer_dwell_timer.sv - free-running dwell counter with one-cycle tick
module dwell_timer #(
   parameter int unsigned DWELL_CYCLES = 66000000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic tick
);
   localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Clear dominates so the count is always zero on the first enabled cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && !clear && (cnt_q == LAST);
endmodule

// File: rtl/plate_char_sequencer.sv
// rtl/plate_char_sequencer.sv - captures recognised plate characters and cycles them on the LED
module plate_char_sequencer #(
   parameter int MAX_CHARS    = plate_pkg::MAX_CHARS,
   parameter int DWELL_CYCLES = 66000000,
   parameter int BLANK_CODE   = plate_pkg::BLANK_CODE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      char_valid,
   input  logic [plate_pkg::CH_W-1:0] char_code,
   input  logic                      rec_done,
   output logic [plate_pkg::CH_W-1:0] led,
   output logic [2:0]                char_count,
   output logic                      display_active,
   output logic                      overflow
);
   import plate_pkg::*;

   localparam logic [CH_W-1:0] BLANK = CH_W'(BLANK_CODE);
   localparam logic [2:0]      MAX_C = 3'(MAX_CHARS);

   state_e          state_q, state_d;
   logic [CH_W-1:0] slots_q [MAX_CHARS];
   logic [CH_W-1:0] slots_d [MAX_CHARS];
   logic [2:0]      count_q, count_d;
   logic [2:0]      idx_q, idx_d, idx_nxt;
   logic [CH_W-1:0] led_q, led_d;
   logic            ovf_q, ovf_d;
   logic            tick;

   dwell_timer #(
      .DWELL_CYCLES(DWELL_CYCLES)
   ) u_dwell_timer (
      .clk   (clk),
      .rst   (rst),
      .enable(state_q == DISPLAY),
      .clear (state_q != DISPLAY),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      slots_d = slots_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      led_d   = led_q;
      idx_nxt = ((count_q <= 3'd1) || (idx_q == count_q - 3'd1)) ? 3'd0 : idx_q + 3'd1;

      if (start) begin
         for (int i = 0; i < MAX_CHARS; i++) begin
            slots_d[i] = BLANK;
         end
         count_d = '0;
         ovf_d   = 1'b0;
         idx_d   = '0;
         led_d   = BLANK;
         state_d = CAPTURE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            CAPTURE: begin
               if (char_valid) begin
                  if (count_q < MAX_C) begin
                     slots_d[count_q] = char_code;
                     count_d          = count_q + 3'd1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               // A character strobed alongside rec_done as the very first one lands in slot 0.
               if (rec_done) begin
                  state_d = DISPLAY;
                  idx_d   = '0;
                  led_d   = (char_valid && count_q == 3'd0 && MAX_C != 3'd0) ? char_code : slots_q[0];
               end
            end
            DISPLAY: begin
               if (tick) begin
                  idx_d = idx_nxt;
                  led_d = (count_q == 3'd0) ? BLANK : slots_q[idx_nxt];
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         for (int i = 0; i < MAX_CHARS; i++) begin
            slots_q[i] <= BLANK;
         end
         count_q <= '0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
         led_q   <= BLANK;
      end else begin
         state_q <= state_d;
         slots_q <= slots_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
         led_q   <= led_d;
      end
   end

   assign led            = led_q;
   assign char_count     = count_q;
   assign display_active = (state_q == DISPLAY);
   assign overflow       = ovf_q;
endmodule

// File: tb/tb_plate_char_sequencer.sv
// tb/tb_plate_char_sequencer.sv - directed and randomized checks against a queue-based plate model
module tb_plate_char_sequencer;
   localparam int DW  = 4;
   localparam int MAXC = 7;
   localparam int BLK = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       char_valid = 1'b0;
   logic [5:0] char_code = '0;
   logic       rec_done = 1'b0;
   logic [5:0] led;
   logic [2:0] char_count;
   logic       display_active;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   // model: mode 0 idle, 1 capture, 2 display; k counts cycles spent in display
   int m_mode = 0;
   int m_q[$];
   bit m_ovf = 0;
   int m_k = 0;

   always #5 clk = ~clk;

   plate_char_sequencer #(
      .MAX_CHARS(MAXC),
      .DWELL_CYCLES(DW),
      .BLANK_CODE(BLK)
   ) dut (
      .clk           (clk),
      .rst           (rst_n),
      .start         (start),
      .char_valid    (char_valid),
      .char_code     (char_code),
      .rec_done      (rec_done),
      .led           (led),
      .char_count    (char_count),
      .display_active(display_active),
      .overflow      (overflow)
   );

   task automatic check_all(input string tag);
      int exp_led;
      exp_led = (m_mode == 2 && m_q.size() > 0) ? m_q[(m_k / DW) % m_q.size()] : BLK;
      checks++;
      assert (led === 6'(exp_led)) else begin
         errors++;
         $error("FAIL %s led got %0d exp %0d", tag, led, exp_led);
      end
      checks++;
      assert (char_count === 3'(m_q.size())) else begin
         errors++;
         $error("FAIL %s char_count got %0d exp %0d", tag, char_count, m_q.size());
      end
      checks++;
      assert (overflow === m_ovf) else begin
         errors++;
         $error("FAIL %s overflow got %0d exp %0d", tag, overflow, m_ovf);
      end
      checks++;
      assert (display_active === (m_mode == 2)) else begin
         errors++;
         $error("FAIL %s display_active got %0d exp %0d", tag, display_active, m_mode == 2);
      end
   endtask

   task automatic cycle(input string tag);
      bit r, s, v, d;
      int c;
      r = rst_n; s = start; v = char_valid; d = rec_done; c = char_code;
      @(posedge clk);
      #1;
      if (!r) begin
         m_mode = 0; m_q.delete(); m_ovf = 0; m_k = 0;
      end else if (s) begin
         m_mode = 1; m_q.delete(); m_ovf = 0; m_k = 0;
      end else if (m_mode == 1) begin
         if (v) begin
            if (m_q.size() < MAXC) m_q.push_back(c);
            else m_ovf = 1;
         end
         if (d) begin
            m_mode = 2; m_k = 0;
         end
      end else if (m_mode == 2) begin
         m_k++;
      end
      check_all(tag);
   endtask

   task automatic drive(input bit s, input bit v, input logic [5:0] c, input bit d, input string tag);
      start = s; char_valid = v; char_code = c; rec_done = d;
      cycle(tag);
      start = 0; char_valid = 0; char_code = '0; rec_done = 0;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) drive(0, 0, 6'd0, 0, tag);
   endtask

   task automatic noise(input int n, input string tag);
      for (int i = 0; i < n; i++)
         drive(0, 1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)), tag);
   endtask

   initial begin
      int n;
      bit merged;
      // reset state
      rst_n = 0;
      cycle("reset");
      cycle("reset2");
      rst_n = 1;
      noise(3, "idle_ignore");

      // three codes then rec_done, led walks 10,11,12,10
      drive(1, 0, 6'd0, 0, "start");
      drive(0, 1, 6'd10, 0, "cap10");
      drive(0, 1, 6'd11, 0, "cap11");
      drive(0, 1, 6'd12, 0, "cap12");
      drive(0, 0, 6'd0, 1, "done3");
      noise(16, "disp3");

      // overflow: nine strobes, only seven kept
      drive(1, 0, 6'd0, 0, "start_ovf");
      for (int i = 1; i <= 9; i++) drive(0, 1, 6'(i), 0, "cap_ovf");
      drive(0, 0, 6'd0, 1, "done_ovf");
      idle(32, "disp_ovf");

      // char_valid and rec_done together after two chars
      drive(1, 0, 6'd0, 0, "start_same");
      drive(0, 1, 6'd20, 0, "cap20");
      drive(0, 1, 6'd21, 0, "cap21");
      drive(0, 1, 6'd5, 1, "same_cycle");
      idle(14, "disp_same");

      // empty plate shows blank
      drive(1, 0, 6'd0, 0, "start_empty");
      drive(0, 0, 6'd0, 1, "done_empty");
      idle(20, "disp_empty");

      // start from display, and start beats a simultaneous strobe
      drive(1, 1, 6'd33, 0, "start_in_disp");
      drive(0, 1, 6'd7, 0, "cap7");
      drive(1, 1, 6'd9, 0, "start_vs_valid");

      // reset mid-capture after four chars, then strobes are ignored
      for (int i = 0; i < 4; i++) drive(0, 1, 6'(30 + i), 0, "cap4");
      rst_n = 0;
      cycle("rst_mid");
      rst_n = 1;
      noise(4, "post_rst");

      // randomized plates
      for (int p = 0; p < 12; p++) begin
         drive(1, 0, 6'd0, 0, "rnd_start");
         n = $urandom_range(0, 9);
         merged = 0;
         for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 2), "rnd_gap");
            if (i == n - 1 && $urandom_range(0, 1) == 1) begin
               drive(0, 1, 6'($urandom), 1, "rnd_last_done");
               merged = 1;
            end else begin
               drive(0, 1, 6'($urandom), 0, "rnd_cap");
            end
         end
         if (p % 4 == 3) begin
            rst_n = 0;
            cycle("rnd_rst");
            rst_n = 1;
            noise(3, "rnd_post_rst");
         end else begin
            if (!merged) drive(0, 0, 6'd0, 1, "rnd_done");
            noise($urandom_range(10, 40), "rnd_disp");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/plate_char_sequencer.md
PLATE_CHAR_SEQUENCER -- requirements
Module: plate_char_sequencer

Interface
REQ-001 SHALL have parameter MAX_CHARS, default 7, meaning plate character slots held.
REQ-002 SHALL have parameter DWELL_CYCLES, default 66000000, meaning clk cycles each character is shown (2 s at 33 MHz).
REQ-003 SHALL have parameter BLANK_CODE, default 40, meaning the 6-bit code driven when there is nothing to show.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock (33 MHz); all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle pulse that clears the buffer and begins capture.
REQ-007 SHALL have port char_valid, input, 1, meaning a one-cycle strobe from the recogniser that char_code is valid.
REQ-008 SHALL have port char_code, input, 6, meaning the recognised character code.
REQ-009 SHALL have port rec_done, input, 1, meaning the recogniser finished the plate.
REQ-010 SHALL have port led, output, 6, meaning the registered character code currently displayed.
REQ-011 SHALL have port char_count, output, 3, meaning the number of characters captured (0..MAX_CHARS).
REQ-012 SHALL have port display_active, output, 1, meaning the block is in DISPLAY.
REQ-013 SHALL have port overflow, output, 1, meaning sticky: more than MAX_CHARS strobes arrived this plate.

Function
REQ-014 SHALL implement states IDLE, CAPTURE and DISPLAY.
REQ-015 IDLE SHALL go to CAPTURE on start, and SHALL ignore char_valid and rec_done.
REQ-016 CAPTURE SHALL go to DISPLAY on rec_done.
REQ-017 DISPLAY SHALL remain in DISPLAY until start or reset.
REQ-018 Start in any state SHALL take effect next cycle: clear the buffer to BLANK_CODE, set char_count=0, clear overflow, drive led=BLANK_CODE, and enter CAPTURE.
REQ-019 In CAPTURE, each char_valid with char_count<MAX_CHARS SHALL write char_code to slot char_count and increment char_count.
REQ-020 A char_valid with char_count==MAX_CHARS SHALL be discarded and SHALL set overflow; buffer contents are retained.
REQ-021 When char_valid and rec_done are asserted in the same cycle, the character SHALL be stored first and then the block SHALL enter DISPLAY.
REQ-022 When start and char_valid are asserted in the same cycle, start SHALL win and the character SHALL be discarded.
REQ-023 On DISPLAY entry, led SHALL show slot 0 in the first DISPLAY cycle (one cycle after rec_done), and the dwell counter SHALL load 0.
REQ-024 In DISPLAY, the displayed index SHALL advance every DWELL_CYCLES cycles.
REQ-025 After slot char_count-1, the index SHALL wrap to 0.
REQ-026 If char_count==1, led SHALL remain on slot 0.
REQ-027 If rec_done arrives with char_count==0, led SHALL hold BLANK_CODE throughout DISPLAY.
REQ-028 The dwell counter SHALL be wide enough for DWELL_CYCLES-1, sized via clog2.
REQ-029 The dwell counter SHALL run only in DISPLAY.
REQ-030 char_valid and rec_done SHALL be ignored in DISPLAY.

Reset
REQ-031 On rst low at a clk edge, the block SHALL enter IDLE.
REQ-032 Reset SHALL set led=BLANK_CODE, char_count=0, overflow=0, display_active=0, all slots=BLANK_CODE, index=0 and dwell counter=0.
REQ-033 Reset mid-DISPLAY or mid-CAPTURE SHALL discard all captured data.
REQ-034 Reset SHALL take priority over start.

Structure
REQ-035 Package plate_pkg SHALL hold CH_W=6, MAX_CHARS, BLANK_CODE and the state enum {IDLE, CAPTURE, DISPLAY}, shared with the recogniser and the top level.
REQ-036 The block SHALL contain exactly one sub-module, dwell_timer, parameterised by DWELL_CYCLES.
REQ-037 dwell_timer SHALL provide inputs enable and clear, and output tick, a one-cycle pulse each DWELL_CYCLES enabled cycles.

Verification (benches use DWELL_CYCLES=4)
REQ-038 The bench SHALL cover: start; codes 10,11,12 strobed; rec_done -> char_count=3 and led sequence 10(x4 cycles),11(x4),12(x4),10...
REQ-039 The bench SHALL cover: 9 strobes with codes 1..9 then rec_done -> char_count=7, overflow=1, display cycles 1..7 only.
REQ-040 The bench SHALL cover: char_valid(code 5) and rec_done in the same cycle after two stored chars -> char_count=3, slot2=5, display_active=1 next cycle.
REQ-041 The bench SHALL cover: rec_done with no chars -> display_active=1 and led=40 held for 20 cycles.
REQ-042 The bench SHALL cover: start while in DISPLAY -> next cycle led=40, char_count=0, overflow=0, state CAPTURE.
REQ-043 The bench SHALL cover: rst low mid-capture after 4 chars -> all outputs at reset values; subsequent strobes without start are ignored.
